// File: rtl/traffic_ranker_if.sv
// Bus bundle for the traffic rank engine: pass request, count snapshot input,
// and the ranked result with its write strobe and status flags.
interface traffic_ranker_if #(
    parameter int N_HOURS = 24,
    parameter int DATA_W  = 15,
    parameter int RANK_W  = 5
);
    logic                        start;
    logic [N_HOURS*DATA_W-1:0]   traffic_data;
    logic [N_HOURS*RANK_W-1:0]   ranked_data;
    logic                        wr_en;
    logic                        busy;
    logic                        done;

    // Requester side: issues start and counts, receives ranks and status
    modport master (
        output start,
        output traffic_data,
        input  ranked_data,
        input  wr_en,
        input  busy,
        input  done
    );

    // Ranker side
    modport slave (
        input  start,
        input  traffic_data,
        output ranked_data,
        output wr_en,
        output busy,
        output done
    );
endinterface

// File: rtl/traffic_ranker.sv
// Traffic rank engine: snapshots N_HOURS hourly counts, then ranks one hour
// per cycle against every hour in parallel (0 = busiest, lower hour wins a
// tie) and publishes all ranks at once with a single-cycle write strobe.
module traffic_ranker #(
    parameter int N_HOURS = 24,
    parameter int DATA_W  = 15,
    parameter int RANK_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    traffic_ranker_if.slave     bus
);

    localparam int IDX_W = (N_HOURS > 1) ? $clog2(N_HOURS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HOURS - 1);

    // Rank sums are RANK_W wide; they must be able to hold N_HOURS-1
    generate
        if ((2 ** RANK_W) < N_HOURS) begin : g_rank_w_check
            $error("traffic_ranker: RANK_W too small for N_HOURS");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RANK = 1'b1
    } state_t;

    state_t                      state_reg;
    logic [IDX_W-1:0]            idx_reg;
    logic [DATA_W-1:0]           snap_reg     [N_HOURS];
    logic [RANK_W-1:0]           rank_buf_reg [N_HOURS];
    logic [N_HOURS*RANK_W-1:0]   ranked_reg;
    logic                        wr_en_reg;
    logic                        done_reg;
    logic                        busy_reg;

    logic [DATA_W-1:0]           cur_count;
    logic [N_HOURS-1:0]          beats;
    logic [RANK_W-1:0]           cur_rank;
    logic [N_HOURS*RANK_W-1:0]   ranked_next;

    assign cur_count = snap_reg[idx_reg];

    // Hour gi outranks the current hour if it is busier, or equally busy
    // with a lower hour index (the current hour never beats itself)
    generate
        for (genvar gi = 0; gi < N_HOURS; gi++) begin : g_cmp
            assign beats[gi] = (snap_reg[gi] > cur_count) ||
                               ((snap_reg[gi] == cur_count) && (IDX_W'(gi) < idx_reg));
        end
    endgenerate

    // Rank of the current hour = number of hours that outrank it
    always_comb begin
        cur_rank = '0;
        for (int k = 0; k < N_HOURS; k++) begin
            cur_rank = cur_rank + RANK_W'(beats[k]);
        end
    end

    // Result image for the completion edge: buffered ranks with the entry
    // being computed this cycle substituted in
    generate
        for (genvar gi = 0; gi < N_HOURS; gi++) begin : g_pack
            assign ranked_next[gi*RANK_W +: RANK_W] =
                (IDX_W'(gi) == idx_reg) ? cur_rank : rank_buf_reg[gi];
        end
    endgenerate

    // Control FSM with registered outputs; one hour ranked per RANK cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            ranked_reg <= '0;
            wr_en_reg  <= 1'b0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            for (int k = 0; k < N_HOURS; k++) begin
                snap_reg[k]     <= '0;
                rank_buf_reg[k] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    wr_en_reg <= 1'b0;
                    done_reg  <= 1'b0;
                    if (bus.start) begin
                        for (int k = 0; k < N_HOURS; k++) begin
                            snap_reg[k] <= bus.traffic_data[k*DATA_W +: DATA_W];
                        end
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RANK;
                    end
                end
                RANK: begin
                    rank_buf_reg[idx_reg] <= cur_rank;
                    if (idx_reg == LAST_IDX) begin
                        ranked_reg <= ranked_next;
                        wr_en_reg  <= 1'b1;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        idx_reg    <= '0;
                        state_reg  <= IDLE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ranked_data = ranked_reg;
    assign bus.wr_en       = wr_en_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_traffic_ranker.sv
// Bench for traffic_ranker: directed and random passes; a reference model
// predicts accepted passes and their results, a monitor checks every cycle.
module tb_traffic_ranker;
    localparam int N = 24;
    localparam int D = 15;
    localparam int R = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    traffic_ranker_if #(.N_HOURS(N), .DATA_W(D), .RANK_W(R)) bus ();

    traffic_ranker #(.N_HOURS(N), .DATA_W(D), .RANK_W(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*R-1:0] ranks;
        int             due;
    } exp_t;

    exp_t           exp_q[$];
    int             left = 0;
    logic [N*R-1:0] hold_exp = '0;

    // Reference ranking: order hours by count descending, stable in hour
    // index, and each hour's rank is its position in that order
    function automatic logic [N*R-1:0] ref_ranks(input logic [N*D-1:0] data);
        int order[$];
        logic [N*R-1:0] res;
        res = '0;
        for (int h = 0; h < N; h++) begin
            int p;
            p = 0;
            while (p < order.size() && data[order[p]*D +: D] >= data[h*D +: D]) p++;
            order.insert(p, h);
        end
        for (int p = 0; p < N; p++) res[order[p]*R +: R] = R'(p);
        return res;
    endfunction

    // Reference control: a pass is accepted when idle, then occupies N edges
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (left > 0) begin
                left = left - 1;
            end else if (bus.start) begin
                exp_t e;
                e.ranks = ref_ranks(bus.traffic_data);
                e.due   = cyc + N;
                exp_q.push_back(e);
                left = N;
            end
        end
    end

    // Reset discards any pass in flight
    always @(negedge rst_n) begin
        exp_q.delete();
        left = 0;
        hold_exp = '0;
    end

    task automatic check(input string name, input logic [N*R-1:0] act, input logic [N*R-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare outputs against the model on every falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_ranked", bus.ranked_data, '0);
            check("reset_flags", {117'd0, bus.wr_en, bus.done, bus.busy}, '0);
        end else begin
            logic exp_wr;
            exp_wr = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("wr_en", {119'd0, bus.wr_en}, {119'd0, exp_wr});
            check("done", {119'd0, bus.done}, {119'd0, exp_wr});
            check("busy", {119'd0, bus.busy}, {119'd0, (left > 0)});
            if (exp_wr) begin
                logic [N-1:0] seen;
                logic perm_ok;
                hold_exp = exp_q[0].ranks;
                void'(exp_q.pop_front());
                seen = '0;
                perm_ok = 1'b1;
                for (int h = 0; h < N; h++) begin
                    int r;
                    r = int'(bus.ranked_data[h*R +: R]);
                    if (r >= N) perm_ok = 1'b0;
                    else if (seen[r]) perm_ok = 1'b0;
                    else seen[r] = 1'b1;
                end
                check("permutation", {119'd0, perm_ok}, {119'd0, 1'b1});
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                void'(exp_q.pop_front());
            end
            check("ranked_data", bus.ranked_data, hold_exp);
            if (bus.wr_en)
                $display("pass result cyc=%0d ranked_data=%h", cyc, bus.ranked_data);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int h = 0; h < N; h++) bus.traffic_data[h*D +: D] = D'(v);
    endtask

    task automatic set_random(input int maxv);
        for (int h = 0; h < N; h++) bus.traffic_data[h*D +: D] = D'($urandom_range(0, maxv));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.traffic_data = '0;
        #2 rst_n = 1'b0;
        wait_cycles(3);
        #2 rst_n = 1'b1;
        wait_cycles(2);

        // Ascending counts: rank[h] = 23-h
        for (int h = 0; h < N; h++) bus.traffic_data[h*D +: D] = D'(h * 10);
        pulse_start();
        wait_cycles(30);

        // All equal: ranks follow hour index
        set_all(16'h0100);
        pulse_start();
        wait_cycles(30);

        // Two saturated peaks and one small count
        set_all(0);
        bus.traffic_data[5*D +: D]  = 15'h7FFF;
        bus.traffic_data[17*D +: D] = 15'h7FFF;
        bus.traffic_data[3*D +: D]  = 15'd1;
        pulse_start();
        wait_cycles(30);

        // Data change and second start mid-pass are ignored
        set_random(32767);
        pulse_start();
        wait_cycles(4);
        set_random(32767);
        wait_cycles(4);
        pulse_start();
        wait_cycles(25);

        // Reset mid-pass aborts it, then a fresh pass completes
        set_random(32767);
        pulse_start();
        wait_cycles(11);
        #2 rst_n = 1'b0;
        #1 check("async_reset_ranked", bus.ranked_data, '0);
        check("async_reset_flags", {117'd0, bus.wr_en, bus.done, bus.busy}, '0);
        wait_cycles(2);
        #2 rst_n = 1'b1;
        wait_cycles(1);
        pulse_start();
        wait_cycles(30);

        // Start held high: back-to-back passes
        set_random(32767);
        @(negedge clk) bus.start = 1'b1;
        wait_cycles(60);
        bus.start = 1'b0;
        wait_cycles(30);

        // Random passes with ties and stray starts
        for (int t = 0; t < 10; t++) begin
            set_random(($urandom_range(0, 1) == 0) ? 3 : 32767);
            pulse_start();
            wait_cycles($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) begin
                set_random(32767);
                pulse_start();
            end
            wait_cycles($urandom_range(0, 30));
        end
        wait_cycles(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_ranker.md
Name: traffic_ranker

Overview:
- Rank engine on the far side of the traffic memory's dual-field words.
- Reads the 24 accumulated hourly counts (the 15-bit count fields) as a snapshot and computes a 5-bit rank per hour.
- Presents the ranks on the ranked-data bus with a one-cycle write strobe; the memory controller maps this strobe onto its rank-field write operation.
- Sequential: one hour ranked per cycle against all hours in parallel.

Parameters:
- N_HOURS, 24, number of hourly entries ranked.
- DATA_W, 15, width of each accumulated count.
- RANK_W, 5, width of each rank; must satisfy 2**RANK_W >= N_HOURS.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request to rank; sampled only in IDLE.
- TRAFFIC_DATA  input  N_HOURS*DATA_W  flattened counts; entry h occupies bits [h*DATA_W +: DATA_W].
- RANKED_DATA  output  N_HOURS*RANK_W  flattened ranks; entry h occupies bits [h*RANK_W +: RANK_W].
- WR_EN  output  1  one-cycle strobe: RANKED_DATA is new and must be written to memory.
- BUSY  output  1  high while a ranking pass is in progress.
- DONE  output  1  one-cycle completion pulse, coincident with WR_EN.

Behaviour:
- Reset (async, RST_N low):
  - state = IDLE, index counter = 0, snapshot and internal rank buffer cleared.
  - RANKED_DATA = 0, WR_EN = 0, BUSY = 0, DONE = 0.
  - Takes effect immediately, including mid-pass; a pass interrupted by reset is discarded and never produces WR_EN.
- States:
  - IDLE -> RANK on edge with START = 1. On that edge: TRAFFIC_DATA is captured into the snapshot, index = 0, BUSY = 1.
  - RANK: each edge computes the rank of snapshot[index] into buffer[index], then index increments.
  - RANK -> IDLE on the edge that processes index = N_HOURS-1. On that edge: buffer (including the final entry) is copied to RANKED_DATA, WR_EN = 1, DONE = 1, BUSY = 0.
  - In IDLE, WR_EN and DONE are forced to 0 on the next edge (exactly one cycle high).
- Latency: START sampled at edge t -> DONE/WR_EN high from edge t+N_HOURS to t+N_HOURS+1 (t+24 to t+25 at defaults).
- TRAFFIC_DATA changes after edge t do not affect the pass; only the snapshot is used.
- Rank rule (0 = busiest hour):
  - rank[i] = number of j with snap[j] > snap[i], plus number of j < i with snap[j] == snap[i].
  - Ties are broken by lower hour index ranking higher.
  - Ranks always form a permutation of 0..N_HOURS-1.
  - Comparisons are unsigned, full DATA_W.
  - Count sum is computed at width RANK_W with no overflow possible; 2**RANK_W >= N_HOURS is checked at elaboration.
- RANKED_DATA holds its last value between passes; it changes only on the completion edge.
- Control edge cases:
  - START while BUSY: ignored, no queuing.
  - START high during the DONE cycle: state is already IDLE, so the new pass is accepted on that edge. BUSY returns to 1 and DONE still drops at that same edge.
  - START held high continuously: passes run back to back, each N_HOURS+1 cycles apart.

Test Plan:
- Ascending counts snap[h] = h*10, START pulse -> after 24 cycles WR_EN/DONE high exactly 1 cycle; rank[h] = 23-h; BUSY high for cycles 1..24.
- All counts = 0x0100 -> rank[h] = h for all h (index tiebreak).
- Counts all 0 except snap[5] = snap[17] = 0x7FFF and snap[3] = 1 -> rank[5] = 0, rank[17] = 1, rank[3] = 2, rank[0] = 3, rank[23] = 23; permutation check passes.
- START pulsed again at cycle 10 of a pass, and TRAFFIC_DATA changed at cycle 5 -> second START ignored; result uses the original snapshot; only one WR_EN pulse.
- RST_N asserted at cycle 12 of a pass, then released, then new START -> outputs 0 immediately on reset; no WR_EN from the aborted pass; new pass completes normally 24 cycles after its START.
- START held high for 60 cycles with fixed data -> WR_EN pulses at cycles 24 and 49; identical RANKED_DATA each pass; DONE never high for two consecutive cycles.
